// File: rtl/accel_flick_conditioner_pkg.sv
// Shared widths, saturation limits and FSM encoding for the accelerometer flick conditioner.
package accel_flick_conditioner_pkg;
  localparam int SAMPLE_W = 12;
  localparam int IO_W     = 16;

  localparam logic signed [SAMPLE_W-1:0] SMP_MAX = 12'sh7FF;
  localparam logic signed [SAMPLE_W-1:0] SMP_MIN = 12'sh800;

  typedef enum logic {
    ST_CAL = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [IO_W-1:0] x);
    if (x > IO_W'(SMP_MAX))      return SMP_MAX;
    else if (x < IO_W'(SMP_MIN)) return SMP_MIN;
    else                         return x[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/accel_axis_path.sv
// One axis: saturate, IIR filter, baseline accumulation and deviation/dead-zone magnitude.
module accel_axis_path
  import accel_flick_conditioner_pkg::*;
#(
  parameter int FILT_SHIFT = 2,
  parameter int CAL_LOG2   = 6,
  parameter int DEADZONE   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  input  logic            first_sample,
  input  logic [IO_W-1:0] din,
  input  logic            cal_add,
  input  logic            cal_load,
  input  logic            cal_clear,
  input  logic            out_load,
  input  logic            out_clear,
  output logic [IO_W-1:0] raw,
  output logic [IO_W-1:0] flick
);
  localparam int ACC_W = SAMPLE_W + FILT_SHIFT + 1;
  localparam int SUM_W = SAMPLE_W + CAL_LOG2;
  localparam int DEV_W = SAMPLE_W + 1;
  localparam logic [SAMPLE_W-1:0] DZ = SAMPLE_W'(DEADZONE);

  logic signed [SAMPLE_W-1:0] s, filt, base, dev;
  logic signed [ACC_W-1:0]    acc, s_ext;
  logic signed [SUM_W-1:0]    sum, sum_next;
  logic signed [DEV_W-1:0]    dev_w;
  logic        [SAMPLE_W-1:0] mag, flick_c;

  assign s        = sat_sample(din);
  assign s_ext    = ACC_W'(s);
  assign filt     = SAMPLE_W'(acc >>> FILT_SHIFT);
  assign sum_next = sum + SUM_W'(filt);
  assign dev_w    = DEV_W'(filt) - DEV_W'(base);
  assign dev      = sat_sample(IO_W'(dev_w));
  // |-2048| does not fit in 12 bits, so it folds onto the positive limit
  assign mag      = (dev == SMP_MIN) ? SMP_MAX : (dev[SAMPLE_W-1] ? -dev : dev);
  assign flick_c  = (mag > DZ) ? mag - DZ : '0;

  // First sample seeds the filter at its settled value so there is no ramp from zero
  always_ff @(posedge clk) begin
    if (rst)               acc <= '0;
    else if (sample_valid) acc <= first_sample ? (s_ext <<< FILT_SHIFT)
                                               : acc + s_ext - (acc >>> FILT_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      base <= '0;
    end else if (cal_clear) begin
      sum  <= '0;
    end else if (cal_add) begin
      if (cal_load) begin
        base <= SAMPLE_W'(sum_next >>> CAL_LOG2);
        sum  <= '0;
      end else begin
        sum  <= sum_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || out_clear) begin
      raw   <= '0;
      flick <= '0;
    end else if (out_load) begin
      raw   <= IO_W'(dev);
      flick <= {{(IO_W-SAMPLE_W){1'b0}}, flick_c};
    end
  end
endmodule

// File: rtl/accel_flick_conditioner.sv
// Top: shared CAL/RUN FSM, calibration sample counter and the two-stage valid pipeline.
module accel_flick_conditioner
  import accel_flick_conditioner_pkg::*;
#(
  parameter int FILT_SHIFT = 2,
  parameter int CAL_LOG2   = 6,
  parameter int DEADZONE   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  input  logic [IO_W-1:0] ax_in,
  input  logic [IO_W-1:0] ay_in,
  input  logic            recal,
  output logic [IO_W-1:0] ax_raw,
  output logic [IO_W-1:0] ay_raw,
  output logic [IO_W-1:0] ax_flick,
  output logic [IO_W-1:0] ay_flick,
  output logic            out_valid,
  output logic            cal_done
);
  localparam int STAGES = 2;

  state_t              state;
  logic [CAL_LOG2-1:0] cnt;
  logic                first_sample;
  logic [STAGES:1]     vld_pipe;
  logic                cal_add, cal_load, out_load;

  assign cal_add   = vld_pipe[1] && (state == ST_CAL) && !recal;
  assign cal_load  = cal_add && (cnt == '1);
  assign out_load  = vld_pipe[1] && (state == ST_RUN) && !recal;
  assign out_valid = vld_pipe[STAGES];
  assign cal_done  = (state == ST_RUN);

  // A sample coinciding with recal still filters but never reaches stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_CAL;
      cnt          <= '0;
      first_sample <= 1'b1;
      vld_pipe     <= '0;
    end else begin
      vld_pipe <= {out_load, sample_valid && !recal};
      if (sample_valid) first_sample <= 1'b0;
      if (recal) begin
        state <= ST_CAL;
        cnt   <= '0;
      end else if (cal_add) begin
        if (cal_load) begin
          cnt   <= '0;
          state <= ST_RUN;
        end else begin
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

  accel_axis_path #(.FILT_SHIFT(FILT_SHIFT), .CAL_LOG2(CAL_LOG2), .DEADZONE(DEADZONE)) u_ax (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .first_sample(first_sample),
    .din(ax_in), .cal_add(cal_add), .cal_load(cal_load), .cal_clear(recal),
    .out_load(out_load), .out_clear(recal), .raw(ax_raw), .flick(ax_flick)
  );

  accel_axis_path #(.FILT_SHIFT(FILT_SHIFT), .CAL_LOG2(CAL_LOG2), .DEADZONE(DEADZONE)) u_ay (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .first_sample(first_sample),
    .din(ay_in), .cal_add(cal_add), .cal_load(cal_load), .cal_clear(recal),
    .out_load(out_load), .out_clear(recal), .raw(ay_raw), .flick(ay_flick)
  );
endmodule

// File: tb/tb_accel_flick_conditioner.sv
// Scoreboard bench: a behavioural model predicts each output beat; a monitor pops and compares.
module tb_accel_flick_conditioner;
  localparam int FS = 2;
  localparam int CL = 6;
  localparam int DZ = 16;

  logic        clk = 1'b0, rst = 1'b1, sample_valid = 1'b0, recal = 1'b0;
  logic [15:0] ax_in = '0, ay_in = '0;
  logic [15:0] ax_raw, ay_raw, ax_flick, ay_flick;
  logic        out_valid, cal_done;

  int total = 0, bad = 0, cyc = 0, ov_seen = 0;

  typedef struct {
    int          due;
    logic [15:0] rx, ry, fx, fy;
  } exp_t;
  exp_t sbq[$];
  exp_t m_last;

  int m_acc[2], m_sum[2], m_base[2];
  int m_cnt;
  bit m_first, m_run;

  accel_flick_conditioner #(.FILT_SHIFT(FS), .CAL_LOG2(CL), .DEADZONE(DZ)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .ax_in(ax_in), .ay_in(ay_in),
    .recal(recal), .ax_raw(ax_raw), .ay_raw(ay_raw), .ax_flick(ax_flick),
    .ay_flick(ay_flick), .out_valid(out_valid), .cal_done(cal_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      ov_seen++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid cyc=%0d got raw=%h/%h flick=%h/%h required no pulse",
                 cyc, ax_raw, ay_raw, ax_flick, ay_flick);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.due || ax_raw !== e.rx || ay_raw !== e.ry ||
            ax_flick !== e.fx || ay_flick !== e.fy) begin
          bad++;
          $display("FAIL scoreboard cyc=%0d got raw=%h/%h flick=%h/%h required cyc=%0d raw=%h/%h flick=%h/%h",
                   cyc, ax_raw, ay_raw, ax_flick, ay_flick, e.due, e.rx, e.ry, e.fx, e.fy);
        end
      end
    end
  end

  function automatic int clamp12(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 2; a++) begin
      m_acc[a] = 0; m_sum[a] = 0; m_base[a] = 0;
    end
    m_cnt = 0; m_first = 1'b1; m_run = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] xi, input logic [15:0] yi, input bit rc);
    int   in_v[2];
    int   filt[2];
    int   s, dev, mag, fl;
    exp_t e;
    in_v[0] = $signed(xi);
    in_v[1] = $signed(yi);
    for (int a = 0; a < 2; a++) begin
      s = clamp12(in_v[a]);
      if (m_first) m_acc[a] = s * (1 << FS);
      else         m_acc[a] = m_acc[a] + s - (m_acc[a] >>> FS);
      filt[a] = m_acc[a] >>> FS;
    end
    m_first = 1'b0;
    if (rc) begin
      m_run = 1'b0; m_cnt = 0; m_sum[0] = 0; m_sum[1] = 0;
      return;
    end
    if (!m_run) begin
      for (int a = 0; a < 2; a++) m_sum[a] += filt[a];
      m_cnt++;
      if (m_cnt == (1 << CL)) begin
        for (int a = 0; a < 2; a++) begin
          m_base[a] = m_sum[a] >>> CL;
          m_sum[a]  = 0;
        end
        m_cnt = 0; m_run = 1'b1;
      end
    end else begin
      e.due = cyc + 2;
      for (int a = 0; a < 2; a++) begin
        dev = clamp12(filt[a] - m_base[a]);
        mag = (dev < 0) ? -dev : dev;
        if (mag > 2047) mag = 2047;
        fl = (mag > DZ) ? mag - DZ : 0;
        if (a == 0) begin e.rx = 16'(dev); e.fx = 16'(fl); end
        else        begin e.ry = 16'(dev); e.fy = 16'(fl); end
      end
      sbq.push_back(e);
      m_last = e;
    end
  endtask

  // Called at a negedge; leaves at a negedge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input bit rc, input int gap);
    ax_in = x; ay_in = y; sample_valid = 1'b1; recal = rc;
    model_step(x, y, rc);
    @(negedge clk);
    sample_valid = 1'b0; recal = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; recal = 1'b0;
    sbq.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic calibrate(input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < (1 << CL); i++) send(x, y, 1'b0, 1);
  endtask

  task automatic settle(input logic [15:0] x, input logic [15:0] y, input int n);
    for (int i = 0; i < n; i++) send(x, y, 1'b0, 1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({ax_raw, ay_raw, ax_flick, ay_flick} !== 64'd0) begin
      bad++; $display("FAIL reset_outputs got %h/%h/%h/%h required all 0", ax_raw, ay_raw, ax_flick, ay_flick);
    end
    total++;
    if ({out_valid, cal_done} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got out_valid=%b cal_done=%b required 0 0", out_valid, cal_done);
    end
  endtask

  task automatic test_cal_rest();
    for (int i = 0; i < (1 << CL) - 1; i++) send(16'd100, 16'hFFCE, 1'b0, 4);
    send(16'd100, 16'hFFCE, 1'b0, 0);
    total++;
    if (cal_done !== 1'b0) begin bad++; $display("FAIL cal_done_early got %b required 0", cal_done); end
    @(negedge clk);
    total++;
    if (cal_done !== 1'b1) begin bad++; $display("FAIL cal_done_rise got %b required 1", cal_done); end
    repeat (3) @(negedge clk);
    send(16'd100, 16'hFFCE, 1'b0, 0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_n1 got out_valid=%b required 0", out_valid); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || {ax_raw, ay_raw, ax_flick, ay_flick} !== 64'd0) begin
      bad++; $display("FAIL rest_output got ov=%b %h/%h/%h/%h required ov=1 all 0",
                      out_valid, ax_raw, ay_raw, ax_flick, ay_flick);
    end
    @(negedge clk);
  endtask

  task automatic test_filter_step();
    int exp_r[3];
    exp_r[0] = 100; exp_r[1] = 175; exp_r[2] = 231;
    do_reset();
    calibrate(16'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      send(16'd400, 16'd0, 1'b0, 2);
      total++;
      if (ax_raw !== 16'(exp_r[k]) || ax_flick !== 16'(exp_r[k] - DZ)) begin
        bad++; $display("FAIL filter_step%0d got raw=%0d flick=%0d required raw=%0d flick=%0d",
                        k, ax_raw, ax_flick, exp_r[k], exp_r[k] - DZ);
      end
    end
    settle(16'd400, 16'd0, 40);
    total++;
    if (ax_raw !== 16'd400 || ax_flick !== 16'd384) begin
      bad++; $display("FAIL filter_converge got raw=%0d flick=%0d required 400 384", ax_raw, ax_flick);
    end
  endtask

  task automatic test_sign_deadzone();
    do_reset();
    calibrate(16'd100, 16'd0);
    settle(16'hFE64, 16'd0, 40);
    total++;
    if (ax_raw !== 16'hFE00 || ax_flick !== 16'd496 || ay_raw !== 16'd0) begin
      bad++; $display("FAIL negative_dev got raw=%h flick=%0d ay_raw=%h required FE00 496 0000",
                      ax_raw, ax_flick, ay_raw);
    end
    settle(16'd110, 16'd0, 40);
    total++;
    if (ax_raw !== 16'd10 || ax_flick !== 16'd0) begin
      bad++; $display("FAIL deadzone got raw=%0d flick=%0d required 10 0", ax_raw, ax_flick);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    calibrate(16'h8000, 16'h7FFF);
    settle(16'h7FFF, 16'h8000, 40);
    total++;
    if (ax_raw !== 16'h07FF || ax_flick !== 16'd2031) begin
      bad++; $display("FAIL sat_pos got raw=%h flick=%0d required 07FF 2031", ax_raw, ax_flick);
    end
    total++;
    if (ay_raw !== 16'hF800 || ay_flick !== 16'd2031) begin
      bad++; $display("FAIL sat_neg got raw=%h flick=%0d required F800 2031", ay_raw, ay_flick);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] x, y;
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) begin
        x = 16'($urandom); y = 16'($urandom);
      end else begin
        x = 16'($urandom_range(0, 1023) - 512 - 2048);
        y = 16'($urandom_range(0, 1023) - 512 - 2048);
      end
      send(x, y, 1'b0, 0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (ax_raw !== m_last.rx || ay_raw !== m_last.ry || ax_flick !== m_last.fx || ay_flick !== m_last.fy) begin
      bad++; $display("FAIL hold_after_burst got %h/%h/%h/%h required %h/%h/%h/%h",
                      ax_raw, ay_raw, ax_flick, ay_flick, m_last.rx, m_last.ry, m_last.fx, m_last.fy);
    end
    repeat (5) @(negedge clk);
    total++;
    if (ax_raw !== m_last.rx || ay_flick !== m_last.fy) begin
      bad++; $display("FAIL hold_idle got raw=%h flick=%h required %h %h", ax_raw, ay_flick, m_last.rx, m_last.fy);
    end
  endtask

  task automatic test_recal();
    repeat (2) @(negedge clk);
    send(16'd50, 16'd50, 1'b1, 0);
    total++;
    if ({ax_raw, ay_raw, ax_flick, ay_flick} !== 64'd0 || cal_done !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL recal_clear got %h/%h/%h/%h cal_done=%b ov=%b required all 0",
                      ax_raw, ay_raw, ax_flick, ay_flick, cal_done, out_valid);
    end
    for (int i = 0; i < (1 << CL) - 1; i++) send(16'd50, 16'd50, 1'b0, 1);
    total++;
    if (cal_done !== 1'b0) begin bad++; $display("FAIL recal_63 got cal_done=%b required 0", cal_done); end
    send(16'd50, 16'd50, 1'b0, 0);
    @(negedge clk);
    total++;
    if (cal_done !== 1'b1) begin bad++; $display("FAIL recal_64 got cal_done=%b required 1", cal_done); end
    send(16'd80, 16'd20, 1'b0, 3);
  endtask

  task automatic test_reset_mid();
    int ov0;
    send(16'd300, 16'd300, 1'b0, 0);
    ov0 = ov_seen;
    do_reset();
    for (int i = 0; i < 30; i++) send(16'd200, 16'd200, 1'b0, 1);
    do_reset();
    for (int i = 0; i < (1 << CL) - 1; i++) send(16'd200, 16'd200, 1'b0, 1);
    total++;
    if (cal_done !== 1'b0) begin bad++; $display("FAIL rst_mid_63 got cal_done=%b required 0", cal_done); end
    send(16'd200, 16'd200, 1'b0, 0);
    @(negedge clk);
    total++;
    if (cal_done !== 1'b1) begin bad++; $display("FAIL rst_mid_64 got cal_done=%b required 1", cal_done); end
    total++;
    if (ov_seen !== ov0) begin
      bad++; $display("FAIL rst_mid_no_valid got pulses=%0d required %0d", ov_seen, ov0);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cal_rest();
    test_filter_step();
    test_sign_deadzone();
    test_saturation();
    test_back_to_back();
    test_recal();
    test_reset_mid();
    repeat (5) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL pending_outputs got %0d outstanding required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/accel_flick_conditioner.md
Name: accel_flick_conditioner

Overview:
- Sits between the SPI accelerometer sample reader and the kinematic/physics stage.
- Saturates raw X/Y samples, low-pass filters them, and removes a calibrated rest-position baseline.
- Produces signed direction outputs (ax_raw, ay_raw) and unsigned dead-zoned flick magnitudes (ax_flick, ay_flick). The physics stage samples these on its 60 Hz tick.
- Runs in the clk domain; samples arrive as sparse single-cycle strobes.

Parameters:
- FILT_SHIFT, 2: IIR smoothing shift, k = 1/2^FILT_SHIFT. Legal range is 0..6.
- CAL_LOG2, 6: calibration averages 2^CAL_LOG2 samples per axis.
- DEADZONE, 16: magnitude subtracted before ax_flick/ay_flick. Results below it read 0.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- sample_valid, input, 1: one-cycle strobe; ax_in/ay_in are valid on this cycle.
- ax_in, input, 16: X sample, signed two's complement.
- ay_in, input, 16: Y sample, signed two's complement.
- recal, input, 1: one-cycle pulse that restarts calibration.
- ax_raw, output, 16: filtered X minus baseline, signed 12-bit result sign-extended to 16.
- ay_raw, output, 16: same as ax_raw, for Y.
- ax_flick, output, 16: unsigned X flick magnitude, 12-bit zero-extended.
- ay_flick, output, 16: same as ax_flick, for Y.
- out_valid, output, 1: one-cycle pulse when the outputs update.
- cal_done, output, 1: high while baseline is valid (state RUN).

Behaviour:
- Reset state: all outputs 0, state CAL, filter and calibration accumulators 0, sample counter 0, first_sample flag set.
- Input saturation: each input is clamped to the 12-bit signed range [-2048, 2047]; call the result s.
- Filter state (per axis):
  - acc, signed, 12+FILT_SHIFT+1 bits; filt = acc >>> FILT_SHIFT (arithmetic).
  - On the first sample after reset: acc <= s << FILT_SHIFT, so there is no ramp from 0.
  - Otherwise, on each sample_valid: acc <= acc + s - (acc >>> FILT_SHIFT).
- Pipeline latency:
  - Cycle N: sample_valid.
  - Cycle N+1: acc updated.
  - Cycle N+2: outputs registered and out_valid pulses.
  - New samples may arrive every cycle (fully pipelined).
- FSM states: CAL and RUN.
- CAL behaviour:
  - On stage-1 completion (cycle N+1) of each sample, add the new filt to the per-axis sum (signed, 12+CAL_LOG2 bits) and increment the counter.
  - When the counter reaches 2^CAL_LOG2: base = sum >>> CAL_LOG2, clear sum and counter, go to RUN.
  - During CAL: outputs are held 0, out_valid stays low, cal_done = 0.
- RUN behaviour (per axis):
  - dev = filt - base, computed at 13 bits and saturated to [-2048, 2047].
  - raw output = sign-extended dev.
  - mag = |dev|, with |-2048| clamped to 2047.
  - flick = mag - DEADZONE if mag > DEADZONE, else 0, zero-extended to 16 bits.
  - cal_done = 1.
- recal:
  - From either state: go to CAL, clear sum and counter, zero the outputs on the next cycle, cal_done drops the next cycle.
  - The filter acc is not cleared.
  - recal on the same cycle as sample_valid: the sample still updates acc, but is not counted toward the new calibration.
- Priority: rst > recal > sample processing.
- Reset mid-pipeline: in-flight samples are discarded and no out_valid is produced.
- Outputs hold their values between out_valid pulses.

Decomposition:
- Shared package holds:
  - the sample width (12) and I/O width (16);
  - saturation limits (2047, -2048);
  - state encodings for CAL and RUN.
- Natural sub-module: accel_axis_path, instantiated twice. It contains saturation, the IIR filter, the calibration accumulator and the deviation/magnitude logic for one axis.
- The top level holds the shared FSM, the sample counter and the out_valid pipeline.

Test Plan:
- Calibration at rest: 64 strobes with ax_in=100, ay_in=-50, spaced 5 cycles apart -> cal_done rises after the 64th sample's stage 1. Next sample gives ax_raw=0, ay_raw=0, flicks 0, with out_valid exactly 2 cycles after sample_valid.
- Filter step: calibrate at 0, then apply ax_in=400 -> successive ax_raw values 100, 175, 231, converging to 400; ax_flick = ax_raw - 16 on each step.
- Sign and dead-zone: calibrate at 100, then hold ax_in=-412 -> ax_raw settles at 0xFE00 (-512) and ax_flick at 496. ax_in=110 -> ax_raw=10, ax_flick=0.
- Saturation: calibrate with ax_in=0x8000 (clamped to -2048), then apply ax_in=0x7FFF -> dev saturates, ax_raw=2047, ax_flick=2031.
- Recal mid-run: pulse recal coincident with sample_valid -> outputs 0 next cycle and cal_done low. Recalibration completes after exactly 64 further samples.
- Reset mid-calibration: assert rst after 30 samples -> a full 64 new samples are required before cal_done, and no out_valid appears before then.
